game_state_ctrl: RTL

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/vga_pkg.sv | 8 +
 rtl/btn_debounce.sv | 37 +++
 rtl/game_state_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: screen state encoding, score width and saturating score increment
package vga_pkg;
  localparam int SCORE_W = 4;
  typedef enum logic [1:0] {START, GAME, PLAYER_1, PLAYER_2} state_t;
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, debouncer and rising-edge pulse for a raw push-button
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button level
//   press    : one-cycle pulse on each debounced 0->1 edge
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic s1, s2, level, level_q;
  logic [CW-1:0] cnt;
  // Reset parks the debounced level high so a button held through reset
  // must be seen released before another press can be reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b1;
      level_q <= 1'b1;
    end else begin
      s1 <= btn;
      s2 <= s1;
      level_q <= level;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign press = level & ~level_q;
endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: screen FSM (START/GAME/PLAYER_1/PLAYER_2) with scores and game reset pulse
//   clk, rst           : clock, synchronous active-high reset
//   start_btn          : raw start button
//   p1_win, p2_win     : round-won pulses from game logic
//   vblnk              : vertical blank, rising edge is the frame tick
//   screen             : current screen
//   game_rst           : one-cycle pulse on entering GAME
//   score_p1, score_p2 : saturating round counters
// Define SCREEN_TIMEOUT_EN to return from win screens after WIN_FRAMES frames.
module game_state_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WIN_FRAMES = 300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               p1_win,
  input  logic               p2_win,
  input  logic               vblnk,
  output state_t             screen,
  output logic               game_rst,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2
);
  logic start_press, expire;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(clk),
    .rst(rst),
    .btn(start_btn),
    .press(start_press)
  );
`ifdef SCREEN_TIMEOUT_EN
  localparam int TW = $clog2(WIN_FRAMES + 1);
  logic vb_q, frame_tick, in_win;
  logic [TW-1:0] frames;
  assign frame_tick = vblnk & ~vb_q;
  assign in_win = screen == PLAYER_1 || screen == PLAYER_2;
  assign expire = in_win && frame_tick && frames == TW'(WIN_FRAMES - 1);
  // Held at zero outside win screens, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      vb_q <= 1'b0;
      frames <= '0;
    end else begin
      vb_q <= vblnk;
      frames <= in_win ? frames + TW'(frame_tick) : '0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = vblnk ^ (WIN_FRAMES == 0);
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      screen <= START;
      game_rst <= 1'b0;
      score_p1 <= '0;
      score_p2 <= '0;
    end else begin
      game_rst <= 1'b0;
      case (screen)
        START: if (start_press) begin
          screen <= GAME;
          game_rst <= 1'b1;
        end
        GAME: if (p1_win) begin
          screen <= PLAYER_1;
          score_p1 <= sat_inc(score_p1);
        end else if (p2_win) begin
          screen <= PLAYER_2;
          score_p2 <= sat_inc(score_p2);
        end
        default: if (start_press || expire) screen <= START;
      endcase
    end
  end
endmodule
